// File: rtl/fuse_mode_controller.sv
// Per-pixel fuser select sequencer. Holds the display mode (colour, edge,
// overlay, split), switches it only at frame boundaries, and registers the
// per-pixel edge/colour select for the fuser.
//
// Request handshake: a request transfers on a rising clk edge where
// mode_req_valid && mode_req_ready. Ready is high only while no request is
// pending; a requester that sees ready low must hold valid and mode_req stable.
module fuse_mode_controller #(
  parameter int          H_ACTIVE    = 1024,
  parameter int          V_ACTIVE    = 768,
  parameter int          AUTO_FRAMES = 120,
  parameter logic [7:0]  EDGE_THRESH = 8'd128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        frame_start,
  input  logic [23:0] edge_pixel,
  input  logic [1:0]  mode_req,
  input  logic        mode_req_valid,
  output logic        mode_req_ready,
  input  logic        auto_en,
  output logic        selectorE,
  output logic [1:0]  active_mode,
  output logic        mode_changed,
  output logic        state_dbg_o     // 1 = a request is pending (PEND)
);

  localparam int          CNT_W    = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_FRAMES - 1);
  localparam logic [10:0] H_LIMIT  = 11'(H_ACTIVE);
  localparam logic [10:0] H_HALF   = 11'(H_ACTIVE / 2);
  localparam logic [9:0]  V_LIMIT  = 10'(V_ACTIVE);

  localparam logic [1:0] MODE_COLOR   = 2'd0;
  localparam logic [1:0] MODE_EDGE    = 2'd1;
  localparam logic [1:0] MODE_OVERLAY = 2'd2;
  localparam logic [1:0] MODE_SPLIT   = 2'd3;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       pending_q, pending_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             changed_q, changed_d;
  logic             sel_q, sel_d;

  logic [7:0] intensity;
  logic       in_area;
  logic       unused_edge_bits;

  assign intensity        = edge_pixel[15:8];
  assign unused_edge_bits = ^{edge_pixel[23:16], edge_pixel[7:0]};
  assign in_area          = (hcount < H_LIMIT) && (vcount < V_LIMIT);

  // State, mode, frame counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RUN;
      pending_q <= MODE_COLOR;
      mode_q    <= MODE_COLOR;
      cnt_q     <= '0;
      changed_q <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
      sel_q     <= sel_d;
    end
  end

  // Mode sequencing: requests are parked in PEND until the next frame start;
  // auto-cycling only advances while no request is pending.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    changed_d = 1'b0;
    if (!auto_en) begin
      cnt_d = '0;
    end
    case (state_q)
      RUN: begin
        if (auto_en && frame_start) begin
          if (cnt_q == CNT_LAST) begin
            mode_d    = mode_q + 2'd1;
            cnt_d     = '0;
            changed_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // A request accepted here never applies in this same frame_start cycle.
        if (mode_req_valid) begin
          pending_d = mode_req;
          state_d   = PEND;
        end
      end
      PEND: begin
        if (frame_start) begin
          mode_d    = pending_q;
          cnt_d     = '0;
          changed_d = (pending_q != mode_q);
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Next per-pixel select, using the mode in effect during the input cycle.
  always_comb begin
    sel_d = 1'b0;
    if (in_area) begin
      case (mode_q)
        MODE_COLOR:   sel_d = 1'b0;
        MODE_EDGE:    sel_d = 1'b1;
        MODE_OVERLAY: sel_d = (intensity >= EDGE_THRESH);
        MODE_SPLIT:   sel_d = (hcount < H_HALF);
        default:      sel_d = 1'b0;
      endcase
    end
  end

  assign mode_req_ready = (state_q == RUN);
  assign selectorE      = sel_q;
  assign active_mode    = mode_q;
  assign mode_changed   = changed_q;
  assign state_dbg_o    = (state_q == PEND);

endmodule
